// File: rtl/apollo_cmd_initiator_pkg.sv
// Shared definitions for the Apollo serial command protocol.
// Opcodes, response codes, ACK byte values, the reply-count table and the
// initiator FSM state encoding. Also used by the responder controller.
package apollo_cmd_initiator_pkg;

    localparam int TIMER_W = 24;

    localparam logic [2:0] CMD_RESET   = 3'd1;
    localparam logic [2:0] CMD_ON      = 3'd2;
    localparam logic [2:0] CMD_OFF     = 3'd3;
    localparam logic [2:0] CMD_STATUS  = 3'd4;
    localparam logic [2:0] CMD_SILENCE = 3'd5;
    localparam logic [2:0] CMD_LEVEL   = 3'd6;

    localparam logic [1:0] RSP_OK      = 2'd0;
    localparam logic [1:0] RSP_NAK     = 2'd1;
    localparam logic [1:0] RSP_TIMEOUT = 2'd2;
    localparam logic [1:0] RSP_BADOP   = 2'd3;

    localparam logic [7:0] ACK_OK   = 8'h01;
    localparam logic [7:0] ACK_FAIL = 8'h02;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAITTX,
        ST_COLLECT,
        ST_GUARD,
        ST_DONE
    } state_t;

    // Number of reply bytes the responder returns for each opcode.
    function automatic logic [1:0] reply_count(input logic [2:0] op);
        case (op)
            CMD_ON, CMD_OFF, CMD_LEVEL: return 2'd1;
            CMD_STATUS:                 return 2'd2;
            default:                    return 2'd0;
        endcase
    endfunction

    // Opcodes followed by a parameter byte on the wire.
    function automatic logic has_param(input logic [2:0] op);
        return (op == CMD_SILENCE) || (op == CMD_LEVEL);
    endfunction

    function automatic logic op_legal(input logic [2:0] op);
        return (op != 3'd0) && (op != 3'd7);
    endfunction

endpackage

// File: rtl/apollo_cmd_initiator_wait_timer.sv
// apollo_wait_timer: loadable down-counter shared by the TX wait, reply
// collection and guard phases of the command initiator.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load         load count with load_val (has priority over tick)
//   load_val     value to load
//   tick         decrement by one; saturates at zero, never wraps
//   expired      count has reached zero
module apollo_wait_timer #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/apollo_cmd_initiator.sv
// apollo_cmd_initiator: host-side master of the Apollo serial command
// protocol. Takes one command, sends opcode (+ parameter) bytes to a UART
// transmitter, collects the reply bytes from a UART receiver and returns one
// result with status. RX bytes arriving while idle are passed through on the
// stream port.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_op/param   command request
//   rsp_valid/rsp_code/rsp_data        one-cycle result pulse, code/data hold
//   tx_in/tx_write/tx_busy             UART transmitter interface
//   rx_out/rx_over                     UART receiver interface (level ready)
//   strm_data/strm_valid               passthrough of idle RX bytes
// Handshake: a command is taken on a clock edge where cmd_valid & cmd_ready;
// cmd_ready is high only in IDLE. rsp_valid has no back-pressure.
// Build option: define APOLLO_CMDI_RETRY_EN to retry a command up to
// MAX_RETRY extra times after a TIMEOUT or NAK.
module apollo_cmd_initiator
    import apollo_cmd_initiator_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int GUARD_CYCLES   = 16,
    parameter int MAX_RETRY      = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    input  logic [2:0]  cmd_op,
    input  logic [7:0]  cmd_param,
    output logic        cmd_ready,
    output logic        rsp_valid,
    output logic [1:0]  rsp_code,
    output logic [15:0] rsp_data,
    output logic [7:0]  tx_in,
    output logic        tx_write,
    input  logic        tx_busy,
    input  logic [7:0]  rx_out,
    input  logic        rx_over,
    output logic [7:0]  strm_data,
    output logic        strm_valid
);

    state_t state, state_nxt;

    logic [2:0]  op_q;
    logic [7:0]  param_q;
    logic        byte_idx;     // 0: opcode byte, 1: parameter byte
    logic [1:0]  rx_cnt;
    logic [15:0] acc;
    logic [15:0] acc_merged;
    logic        seen_busy;
    logic        rx_prev;
    logic        rx_new;       // registered rising edge of rx_over
    logic [7:0]  rx_byte;

    logic               t_load, t_tick, t_expired;
    logic [TIMER_W-1:0] t_val;

    logic       accept, do_write, next_byte, clr_collect, store;
    logic       fail, finish, retry;
    logic [1:0] fin_code;
    logic [15:0] fin_data;

`ifdef APOLLO_CMDI_RETRY_EN
    logic [3:0] retry_cnt;
`else
    logic unused_cfg;
    assign unused_cfg = ^MAX_RETRY;
`endif

    apollo_wait_timer #(.W(TIMER_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (t_load),
        .load_val (t_val),
        .tick     (t_tick),
        .expired  (t_expired)
    );

    // Reply byte k lands in rsp_data[15-8k -: 8].
    always_comb begin
        acc_merged = acc;
        if (rx_cnt[0]) acc_merged[7:0]  = rx_byte;
        else           acc_merged[15:8] = rx_byte;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        do_write    = 1'b0;
        next_byte   = 1'b0;
        clr_collect = 1'b0;
        store       = 1'b0;
        fail        = 1'b0;
        finish      = 1'b0;
        retry       = 1'b0;
        fin_code    = RSP_OK;
        fin_data    = '0;
        t_load      = 1'b0;
        t_tick      = 1'b0;
        t_val       = TIMER_W'(TIMEOUT_CYCLES);

        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    accept = 1'b1;
                    if (!op_legal(cmd_op)) begin
                        finish    = 1'b1;
                        fin_code  = RSP_BADOP;
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                if (!tx_busy) begin
                    do_write  = 1'b1;
                    t_load    = 1'b1;
                    state_nxt = ST_WAITTX;
                end
            end
            ST_WAITTX: begin
                // A byte is complete only once busy has been seen high and dropped.
                if (seen_busy && !tx_busy) begin
                    if (!byte_idx && has_param(op_q)) begin
                        next_byte = 1'b1;
                        state_nxt = ST_SEND;
                    end else if (reply_count(op_q) == 2'd0) begin
                        t_load    = 1'b1;
                        t_val     = TIMER_W'(GUARD_CYCLES);
                        state_nxt = ST_GUARD;
                    end else begin
                        t_load      = 1'b1;
                        clr_collect = 1'b1;
                        state_nxt   = ST_COLLECT;
                    end
                end else if (t_expired) begin
                    fail     = 1'b1;
                    fin_code = RSP_TIMEOUT;
                end else begin
                    t_tick = 1'b1;
                end
            end
            ST_COLLECT: begin
                if (rx_new) begin
                    store  = 1'b1;
                    t_load = 1'b1;
                    if ((rx_cnt + 2'd1) == reply_count(op_q)) begin
                        fin_data = acc_merged;
                        if ((op_q == CMD_STATUS) || (acc_merged[15:8] == ACK_OK)) begin
                            finish    = 1'b1;
                            state_nxt = ST_DONE;
                        end else begin
                            fail     = 1'b1;
                            fin_code = RSP_NAK;
                        end
                    end
                end else if (t_expired) begin
                    fail     = 1'b1;
                    fin_code = RSP_TIMEOUT;
                    fin_data = acc;
                end else begin
                    t_tick = 1'b1;
                end
            end
            ST_GUARD: begin
                if (t_expired) begin
                    finish    = 1'b1;
                    state_nxt = ST_DONE;
                end else begin
                    t_tick = 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (fail) begin
`ifdef APOLLO_CMDI_RETRY_EN
            if (32'(retry_cnt) < MAX_RETRY) begin
                retry     = 1'b1;
                state_nxt = ST_SEND;
            end else begin
                finish    = 1'b1;
                state_nxt = ST_DONE;
            end
`else
            finish    = 1'b1;
            state_nxt = ST_DONE;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= '0;
            param_q    <= '0;
            byte_idx   <= 1'b0;
            rx_cnt     <= '0;
            acc        <= '0;
            seen_busy  <= 1'b0;
            rx_prev    <= 1'b0;
            rx_new     <= 1'b0;
            rx_byte    <= '0;
            tx_in      <= '0;
            tx_write   <= 1'b0;
            rsp_code   <= '0;
            rsp_data   <= '0;
            strm_data  <= '0;
            strm_valid <= 1'b0;
`ifdef APOLLO_CMDI_RETRY_EN
            retry_cnt  <= '0;
`endif
        end else begin
            rx_prev <= rx_over;
            rx_new  <= rx_over & ~rx_prev;
            if (rx_over && !rx_prev) rx_byte <= rx_out;

            // Only bytes seen while idle are unsolicited.
            strm_valid <= (state == ST_IDLE) && rx_new;
            if ((state == ST_IDLE) && rx_new) strm_data <= rx_byte;

            tx_write <= do_write;
            if (do_write) tx_in <= byte_idx ? param_q : {5'b0, op_q};

            if (do_write)     seen_busy <= 1'b0;
            else if (tx_busy) seen_busy <= 1'b1;

            if (accept) begin
                op_q     <= cmd_op;
                param_q  <= cmd_param;
                byte_idx <= 1'b0;
`ifdef APOLLO_CMDI_RETRY_EN
                retry_cnt <= '0;
`endif
            end
            if (next_byte) byte_idx <= 1'b1;
            if (retry) begin
                byte_idx <= 1'b0;
`ifdef APOLLO_CMDI_RETRY_EN
                retry_cnt <= retry_cnt + 4'd1;
`endif
            end

            if (clr_collect) begin
                rx_cnt <= '0;
                acc    <= '0;
            end else if (store) begin
                rx_cnt <= rx_cnt + 2'd1;
                acc    <= acc_merged;
            end

            if (finish) begin
                rsp_code <= fin_code;
                rsp_data <= fin_data;
            end
        end
    end

    assign cmd_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_DONE);

endmodule

// File: tb/tb_apollo_cmd_initiator.sv
// Bench for apollo_cmd_initiator: directed commands against a UART TX busy
// model and a byte-level RX driver; TX bytes, results and stream bytes are
// checked by monitors popping expected queues.
module tb_apollo_cmd_initiator;

    localparam int TOUT    = 200;
    localparam int GUARD   = 16;
    localparam int TX_BUSY = 10;
`ifdef APOLLO_CMDI_RETRY_EN
    localparam int ATTEMPTS = 3;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_param;
    logic        cmd_ready;
    logic        rsp_valid;
    logic [1:0]  rsp_code;
    logic [15:0] rsp_data;
    logic [7:0]  tx_in;
    logic        tx_write;
    logic        tx_busy;
    logic [7:0]  rx_out;
    logic        rx_over;
    logic [7:0]  strm_data;
    logic        strm_valid;

    int errors = 0;
    int checks = 0;
    int tx_cnt = 0;
    int rsp_cnt = 0;

    logic [7:0]  exp_tx_q[$];
    logic [17:0] exp_rsp_q[$];
    logic [7:0]  exp_strm_q[$];

    apollo_cmd_initiator #(
        .TIMEOUT_CYCLES (TOUT),
        .GUARD_CYCLES   (GUARD),
        .MAX_RETRY      (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_op     (cmd_op),
        .cmd_param  (cmd_param),
        .cmd_ready  (cmd_ready),
        .rsp_valid  (rsp_valid),
        .rsp_code   (rsp_code),
        .rsp_data   (rsp_data),
        .tx_in      (tx_in),
        .tx_write   (tx_write),
        .tx_busy    (tx_busy),
        .rx_out     (rx_out),
        .rx_over    (rx_over),
        .strm_data  (strm_data),
        .strm_valid (strm_valid)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- check helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- UART TX busy model ----------------
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && tx_write) begin
                tx_cnt++;
                tx_busy = 1'b1;
                repeat (TX_BUSY) @(negedge clk);
                tx_busy = 1'b0;
            end
        end
    end

    // ---------------- monitors / scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n && tx_write) begin
            if (exp_tx_q.size() == 0) chk("tx_unexpected", {24'b0, tx_in}, 32'hFFFF_FFFF);
            else chk("tx_byte", {24'b0, tx_in}, {24'b0, exp_tx_q.pop_front()});
        end
        if (rst_n && rsp_valid) begin
            rsp_cnt++;
            if (exp_rsp_q.size() == 0) chk("rsp_unexpected", {14'b0, rsp_code, rsp_data}, 32'hFFFF_FFFF);
            else chk("rsp_code_data", {14'b0, rsp_code, rsp_data}, {14'b0, exp_rsp_q.pop_front()});
        end
        if (rst_n && strm_valid) begin
            if (exp_strm_q.size() == 0) chk("strm_unexpected", {24'b0, strm_data}, 32'hFFFF_FFFF);
            else chk("strm_data", {24'b0, strm_data}, {24'b0, exp_strm_q.pop_front()});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [2:0] op, input logic [7:0] param);
        int i;
        i = 0;
        while (!cmd_ready && i < 5000) begin
            @(negedge clk);
            i++;
        end
        if (!cmd_ready) chk("cmd_ready_wait", 32'd0, 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_param = param;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_param = 8'd0;
    endtask

    task automatic wait_tx(input int target);
        int i;
        i = 0;
        while (!(tx_cnt >= target && !tx_busy) && i < 3000) begin
            @(negedge clk);
            i++;
        end
        if (!(tx_cnt >= target && !tx_busy)) chk("tx_done_wait", tx_cnt, target);
    endtask

    task automatic wait_rsp(input int target);
        int i;
        i = 0;
        while (rsp_cnt < target && i < 5000) begin
            @(negedge clk);
            i++;
        end
        if (rsp_cnt < target) chk("rsp_wait", rsp_cnt, target);
    endtask

    task automatic send_rx(input logic [7:0] b);
        @(negedge clk);
        rx_out  = b;
        rx_over = 1'b1;
        repeat (3) @(negedge clk);
        rx_over = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // One command: expected TX bytes for each attempt, replies sent per attempt.
    task automatic run_cmd(input logic [2:0] op, input logic [7:0] param, input int nrep,
                           input logic [7:0] r0, input logic [7:0] r1, input int attempts,
                           input logic [1:0] code, input logic [15:0] data);
        int t0, r_base, nb;
        t0     = tx_cnt;
        r_base = rsp_cnt;
        nb     = (op == 3'd5 || op == 3'd6) ? 2 : 1;
        for (int a = 0; a < attempts; a++) begin
            exp_tx_q.push_back({5'b0, op});
            if (nb == 2) exp_tx_q.push_back(param);
        end
        exp_rsp_q.push_back({code, data});
        issue(op, param);
        for (int a = 0; a < attempts; a++) begin
            wait_tx(t0 + (a + 1) * nb);
            repeat (2) @(negedge clk);
            if (nrep > 0) send_rx(r0);
            if (nrep > 1) send_rx(r1);
        end
        wait_rsp(r_base + 1);
        repeat (3) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_param = 8'd0;
        rx_out    = 8'd0;
        rx_over   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset_rsp_code", {30'b0, rsp_code}, 32'd0);
        chk("reset_rsp_data", {16'b0, rsp_data}, 32'd0);
        chk("reset_tx_write", {31'b0, tx_write}, 32'd0);
        chk("reset_tx_in", {24'b0, tx_in}, 32'd0);
        chk("reset_strm_valid", {31'b0, strm_valid}, 32'd0);
        chk("reset_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // ON, ack -> OK 0x0100
        run_cmd(3'd2, 8'h00, 1, 8'h01, 8'h00, 1, 2'd0, 16'h0100);
        // STATUS, two reply bytes -> OK 0x0364
        run_cmd(3'd4, 8'h00, 2, 8'h03, 8'h64, 1, 2'd0, 16'h0364);
        // LEVEL 0x50, ack -> OK 0x0100
        run_cmd(3'd6, 8'h50, 1, 8'h01, 8'h00, 1, 2'd0, 16'h0100);

        // Idle RX bytes stream through.
        exp_strm_q.push_back(8'hA5);
        exp_strm_q.push_back(8'h5A);
        send_rx(8'hA5);
        send_rx(8'h5A);
        repeat (5) @(negedge clk);

        // SILENCE 0x01, no reply -> OK after guard
        run_cmd(3'd5, 8'h01, 0, 8'h00, 8'h00, 1, 2'd0, 16'h0000);
        // LEVEL 0x10, fail ack -> NAK 0x0200
        run_cmd(3'd6, 8'h10, 1, 8'h02, 8'h00, ATTEMPTS, 2'd1, 16'h0200);
        // OFF, no reply -> TIMEOUT
        run_cmd(3'd3, 8'h00, 0, 8'h00, 8'h00, ATTEMPTS, 2'd2, 16'h0000);
        chk("timeout_code_held", {30'b0, rsp_code}, 32'd2);

        // Reset mid-command: abort, no result.
        t0 = tx_cnt;
        exp_tx_q.push_back(8'h02);
        issue(3'd2, 8'h00);
        wait_tx(t0 + 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("midrst_rsp_code", {30'b0, rsp_code}, 32'd0);
        chk("midrst_tx_write", {31'b0, tx_write}, 32'd0);
        rst_n = 1'b1;
        repeat (TOUT + 20) @(negedge clk);
        chk("midrst_no_rsp", {31'b0, rsp_valid}, 32'd0);

        // Illegal opcodes: no TX, BADOP.
        run_cmd(3'd7, 8'h00, 0, 8'h00, 8'h00, 0, 2'd3, 16'h0000);
        run_cmd(3'd0, 8'h00, 0, 8'h00, 8'h00, 0, 2'd3, 16'h0000);

        repeat (10) @(negedge clk);
        chk("tx_queue_empty", exp_tx_q.size(), 32'd0);
        chk("rsp_queue_empty", exp_rsp_q.size(), 32'd0);
        chk("strm_queue_empty", exp_strm_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
